// File: rtl/scan_timing_gen.sv
// rtl/scan_timing_gen.sv - 640x480 raster scan counters, sync/active decode and output alignment delay
module scan_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] horz,
    output logic [9:0] vert,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VIS);
    localparam logic [9:0] V_ACT    = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);
    localparam logic       SYNC_OFF = !SYNC_ON;

    logic [3:0] div_cnt;
    logic       advance;
    logic [9:0] horz_nxt;
    logic [9:0] vert_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       vid_nxt;
    logic       hs_r;
    logic       vs_r;
    logic       vid_r;

    assign advance = (div_cnt == DIV_LAST);

    // Decode is taken from the next counter values so it registers alongside horz/vert.
    always_comb begin
        horz_nxt = horz + 10'd1;
        vert_nxt = vert;
        if (horz == H_LAST) begin
            horz_nxt = '0;
            vert_nxt = (vert == V_LAST) ? '0 : vert + 10'd1;
        end
        hs_nxt  = ((horz_nxt >= HS_START) && (horz_nxt < HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_nxt  = ((vert_nxt >= VS_START) && (vert_nxt < VS_END)) ? SYNC_ON : SYNC_OFF;
        vid_nxt = (horz_nxt < H_ACT) && (vert_nxt < V_ACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            horz        <= H_LAST;
            vert        <= V_LAST;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            hs_r        <= SYNC_OFF;
            vs_r        <= SYNC_OFF;
            vid_r       <= 1'b0;
        end else begin
            pix_tick    <= advance;
            frame_start <= advance && (horz_nxt == '0) && (vert_nxt == '0);
            if (advance) begin
                div_cnt <= '0;
                horz    <= horz_nxt;
                vert    <= vert_nxt;
                hs_r    <= hs_nxt;
                vs_r    <= vs_nxt;
                vid_r   <= vid_nxt;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    // Free-running delay line matches the one-clock read latency of the drawing blocks.
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hsync    = hs_r;
            assign vsync    = vs_r;
            assign video_on = vid_r;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe;
            logic [PIPE_DLY-1:0] vs_pipe;
            logic [PIPE_DLY-1:0] vid_pipe;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hs_pipe  <= {PIPE_DLY{SYNC_OFF}};
                    vs_pipe  <= {PIPE_DLY{SYNC_OFF}};
                    vid_pipe <= '0;
                end else begin
                    hs_pipe[0]  <= hs_r;
                    vs_pipe[0]  <= vs_r;
                    vid_pipe[0] <= vid_r;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_pipe[i]  <= hs_pipe[i-1];
                        vs_pipe[i]  <= vs_pipe[i-1];
                        vid_pipe[i] <= vid_pipe[i-1];
                    end
                end
            end

            assign hsync    = hs_pipe[PIPE_DLY-1];
            assign vsync    = vs_pipe[PIPE_DLY-1];
            assign video_on = vid_pipe[PIPE_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_scan_timing_gen.sv
// tb/tb_scan_timing_gen.sv - directed self-checking bench for scan_timing_gen
module tb_scan_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    logic [9:0] d_horz, d_vert, p_horz, p_vert, s_horz, s_vert;
    logic d_tick, d_fs, d_hs, d_vs, d_vid;
    logic p_tick, p_fs, p_hs, p_vs, p_vid;
    logic s_tick, s_fs, s_hs, s_vs, s_vid;

    scan_timing_gen u_def (
        .clk(clk), .reset(rst), .horz(d_horz), .vert(d_vert), .pix_tick(d_tick),
        .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .video_on(d_vid)
    );

    scan_timing_gen #(.PIPE_DLY(3)) u_p3 (
        .clk(clk), .reset(rst), .horz(p_horz), .vert(p_vert), .pix_tick(p_tick),
        .frame_start(p_fs), .hsync(p_hs), .vsync(p_vs), .video_on(p_vid)
    );

    // Shrunken raster: H_TOTAL=15, V_TOTAL=10, 150 ticks/frame, 300 clks/frame.
    scan_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .CLK_DIV(2), .PIPE_DLY(0)
    ) u_small (
        .clk(clk), .reset(rst_s), .horz(s_horz), .vert(s_vert), .pix_tick(s_tick),
        .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int ticks, hs_low, vid_hi, h656, hs_fall, p_fall, vid_first, fs_cnt, vs_hi, s_h10, s_hs_first;
    bit found;

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_horz", d_horz, 799);
        check("rst_vert", d_vert, 524);
        check("rst_vid", d_vid, 0);
        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_tick", d_tick, 0);
        check("s_rst_hsync", s_hs, 0);
        check("s_rst_vsync", s_vs, 0);

        // Default timing: first tick on the 4th edge after release.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_horz", d_horz, 799);
        check("pre_tick", d_tick, 0);
        @(negedge clk);
        check("first_horz", d_horz, 0);
        check("first_vert", d_vert, 0);
        check("first_tick", d_tick, 1);
        check("first_fs", d_fs, 1);
        check("first_vid_delayed", d_vid, 0);

        ticks = 0; hs_low = 0; vid_hi = 0; h656 = -1; hs_fall = -1; p_fall = -1; vid_first = -1;
        for (int i = 0; i < 3200; i++) begin
            if (d_tick) ticks++;
            if (!d_hs) hs_low++;
            if (d_vid) vid_hi++;
            if (h656 < 0 && d_horz == 10'd656) h656 = i;
            if (hs_fall < 0 && !d_hs) hs_fall = i;
            if (p_fall < 0 && !p_hs) p_fall = i;
            if (vid_first < 0 && d_vid) vid_first = i;
            if (d_vs !== 1'b1) check("line0_vsync", d_vs, 1);
            @(negedge clk);
        end
        check("line_ticks", ticks, 800);
        check("line_hs_low_clks", hs_low, 384);
        check("line_vid_clks", vid_hi, 2560);
        check("vid_first_clk", vid_first, 1);
        check("horz656_clk", h656, 2624);
        check("hs_fall_dly1", hs_fall, 2625);
        check("hs_fall_dly3", p_fall, 2627);
        check("line_wrap_horz", d_horz, 0);
        check("line_wrap_vert", d_vert, 1);
        check("line_wrap_fs", d_fs, 0);

        // Shrunken raster: CLK_DIV=2, PIPE_DLY=0, SYNC_POL=1.
        rst_s = 1'b0;
        @(negedge clk);
        check("s_pre_tick_horz", s_horz, 14);
        @(negedge clk);
        check("s_first_horz", s_horz, 0);
        check("s_first_vert", s_vert, 0);
        check("s_first_fs", s_fs, 1);
        check("s_first_vid", s_vid, 1);

        ticks = 0; fs_cnt = 0; vs_hi = 0; vid_hi = 0; hs_low = 0; s_h10 = -1; s_hs_first = -1;
        for (int i = 0; i < 300; i++) begin
            if (s_tick) ticks++;
            if (s_fs) fs_cnt++;
            if (s_vs) vs_hi++;
            if (s_vid) vid_hi++;
            if (s_hs) hs_low++;
            if (s_h10 < 0 && s_horz == 10'd10) s_h10 = i;
            if (s_hs_first < 0 && s_hs) s_hs_first = i;
            if (i == 1) check("s_tick_i1", s_tick, 0);
            if (i == 2) check("s_tick_i2", s_tick, 1);
            if (i == 58) begin
                check("s_pre_wrap_h", s_horz, 14);
                check("s_pre_wrap_v", s_vert, 1);
            end
            if (i == 60) begin
                check("s_line_wrap_h", s_horz, 0);
                check("s_line_wrap_v", s_vert, 2);
            end
            if (i == 298) begin
                check("s_frame_end_h", s_horz, 14);
                check("s_frame_end_v", s_vert, 9);
            end
            @(negedge clk);
        end
        check("s_frame_ticks", ticks, 150);
        check("s_frame_fs", fs_cnt, 1);
        check("s_vsync_clks", vs_hi, 60);
        check("s_vid_clks", vid_hi, 96);
        check("s_hsync_clks", hs_low, 60);
        check("s_h10_clk", s_h10, 20);
        check("s_hs_same_clk", s_hs_first, 20);
        check("s_wrap_h", s_horz, 0);
        check("s_wrap_v", s_vert, 0);
        check("s_wrap_fs", s_fs, 1);

        // Mid-frame reset at (5,3).
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (s_horz == 10'd5 && s_vert == 10'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_found", int'(found), 1);
        rst_s = 1'b1;
        #1;
        check("mid_rst_horz", s_horz, 14);
        check("mid_rst_vert", s_vert, 9);
        check("mid_rst_hsync", s_hs, 0);
        check("mid_rst_vid", s_vid, 0);
        check("mid_rst_tick", s_tick, 0);
        @(negedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        @(negedge clk);
        check("mid_pre_tick_horz", s_horz, 14);
        @(negedge clk);
        check("mid_restart_h", s_horz, 0);
        check("mid_restart_v", s_vert, 0);
        check("mid_restart_fs", s_fs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_timing_gen.md
# scan_timing_gen

Generates the 640x480 raster scan that drives the display pipeline. Divides the system clock into a pixel tick, maintains horizontal and vertical position counters, and decodes sync and active-video windows. Its `horz`/`vert` outputs feed the icon and map drawing blocks. Sync and active-video outputs are delayed so they align with the one-clock memory read latency of those blocks before reaching the colorizer and VGA pins.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active low)
- CLK_DIV, 4, system clocks per pixel (legal range 2..16)
- PIPE_DLY, 1, clocks of delay on hsync/vsync/video_on relative to horz/vert (legal range 0..4)

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- horz  out  10  current pixel column, 0..H_TOTAL-1
- vert  out  10  current line, 0..V_TOTAL-1
- pix_tick  out  1  one-clk pulse when horz/vert take a new value
- frame_start  out  1  one-clk pulse coincident with the pix_tick that enters (0,0)
- hsync  out  1  horizontal sync, delayed PIPE_DLY clocks
- vsync  out  1  vertical sync, delayed PIPE_DLY clocks
- video_on  out  1  high in visible region, delayed PIPE_DLY clocks

## Operation
- Derived values:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP, which is 800 at defaults.
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP, which is 525 at defaults.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. "Advance edge" is the clk edge where div_cnt == CLK_DIV-1.
- On each advance edge:
  - If horz == H_TOTAL-1: horz <= 0. Otherwise horz <= horz+1.
  - If horz == H_TOTAL-1 and vert == V_TOTAL-1: vert <= 0.
  - Else if horz == H_TOTAL-1: vert <= vert+1.
  - Otherwise vert holds.
- Sync and active-video decode, applied to the new counter values:
  - Undelayed hsync is asserted (level SYNC_POL) for H_VIS+H_FP <= horz < H_VIS+H_FP+H_SYNC. At defaults this is 656..751.
  - Undelayed vsync is asserted for V_VIS+V_FP <= vert < V_VIS+V_FP+V_SYNC. At defaults this is 490..491.
  - Undelayed video_on = (horz < H_VIS) && (vert < V_VIS).
- The decode result is registered on the same edge as the counters. It then passes through a PIPE_DLY-stage shift register clocked every clk, not gated by the tick.
- PIPE_DLY = 0 means the undelayed registered values drive the outputs directly.
- All counter comparisons are unsigned. The 10-bit widths cover totals up to 1023; totals above that are illegal.

## Timing
- Reset values (asynchronous):
  - div_cnt = 0
  - horz = H_TOTAL-1 (799), vert = V_TOTAL-1 (524)
  - pix_tick = 0, frame_start = 0, video_on = 0
  - hsync = vsync = ~SYNC_POL (deasserted)
  - Every delay stage holds its deasserted value.
- The first advance edge is the CLK_DIV-th rising edge after reset deasserts. It takes the counters to (0,0) and pulses pix_tick and frame_start.
- pix_tick is registered: high for exactly one clk following each advance edge, once every CLK_DIV clocks.
- horz/vert are stable for CLK_DIV clocks between ticks.
- hsync, vsync and video_on change exactly PIPE_DLY clocks after the corresponding horz/vert change.
- Reset asserted mid-frame: all outputs return immediately to reset values. The first tick after release restarts at (0,0) with frame_start.
- Line wrap and frame wrap occur on the same edge. At (799,524) → (0,0) the vert wrap and frame_start coincide. There is no extra idle tick.

## Test plan
- Reset release, defaults:
  - horz=799, vert=524, video_on=0, hsync=vsync=1 during reset.
  - The 4th clk edge after release gives horz=0, vert=0, and pix_tick and frame_start high for one clk.
  - video_on=1 one clk later (PIPE_DLY=1).
- Line timing:
  - Count ticks per line = 800.
  - hsync low for exactly 96 ticks (384 clks), starting when horz becomes 656.
  - video_on high for 640 ticks per visible line.
- Frame timing:
  - frame_start period = 800*525*4 = 1,680,000 clks.
  - vsync low only for vert 490..491 (1600 ticks).
  - video_on low for all of lines 480..524.
- Wrap boundary: at (799,524) the next tick gives (0,0) with frame_start. At (799,10) the next tick gives (0,11).
- Parameter sweep:
  - CLK_DIV=2 gives pix_tick every 2 clks.
  - PIPE_DLY=0 gives hsync falling on the same clk horz becomes 656.
  - PIPE_DLY=3 puts that edge 3 clks later.
  - SYNC_POL=1 inverts hsync/vsync, including reset level 0.
- Mid-frame reset: assert reset at (300,200) for 2 clks. Outputs go immediately to reset values. After release, the first tick gives (0,0) with frame_start.
